// File: rtl/hs_cdc_pkg.sv
// Shared definitions for the four-phase req/ack clock-domain-crossing pair.
// Contents:
//   rx_state_e  - RX handshake FSM state, one-hot
//   tx_state_e  - TX handshake FSM state encodings
//   SYNC_STAGES - depth of the req/ack synchronisers
package hs_cdc_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    RX_WAIT_LOW = 3'b001,
    RX_IDLE     = 3'b010,
    RX_ASSERT   = 3'b100
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE     = 2'b00,
    TX_REQ      = 2'b01,
    TX_WAIT_ACK = 2'b10
  } tx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with a synchronous, active-low reset.
// Ports:
//   clk_i - destination-domain clock
//   rst_n - synchronous active-low reset; both flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronised output
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/full_handshake_rx.sv
// Receive side of the four-phase req/ack CDC handshake. Synchronises req_i,
// captures req_data_i, returns ack_o and hands each word to the local consumer
// through a one-entry valid/ready buffer.
// Ports:
//   clk_i        - RX-domain clock
//   rst_n        - synchronous active-low reset
//   req_i        - TX request (asynchronous to clk_i)
//   req_data_i   - TX data, stable while req_i is high
//   ack_o        - registered acknowledge to TX
//   data_o       - captured word
//   data_valid_o - data_o holds an unconsumed word
//   data_ready_i - consumer accepts data_o
//   idle_o       - FSM is in IDLE
//
// state       | meaning
// ------------+------------------------------------------------------------
// RX_WAIT_LOW | after reset; wait for req_s low so an in-flight request
//             | from before the reset is never captured
// RX_IDLE     | ready; capture on req_s high when the buffer can take a word
// RX_ASSERT   | ack high; wait for req_s low to complete the handshake
module full_handshake_rx
  import hs_cdc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          req_i,
  input  logic [DW-1:0] req_data_i,
  output logic          ack_o,
  output logic [DW-1:0] data_o,
  output logic          data_valid_o,
  input  logic          data_ready_i,
  output logic          idle_o
);

  rx_state_e state;
  logic      req_s;
  logic      capture;

  // Resets to 1 so a request already high during reset reads as "busy".
  sync_2ff #(.RST_VAL(1'b1)) u_req_sync (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .d     (req_i),
    .q     (req_s)
  );

  // Buffer is free if empty or being drained on this same edge.
  assign capture = (state == RX_IDLE) && req_s && (!data_valid_o || data_ready_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state        <= RX_WAIT_LOW;
      ack_o        <= 1'b0;
      idle_o       <= 1'b0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
    end else begin
      // A simultaneous drain and capture keeps valid high with the new word.
      if (capture) begin
        data_o       <= req_data_i;
        data_valid_o <= 1'b1;
      end else if (data_valid_o && data_ready_i) begin
        data_valid_o <= 1'b0;
      end

      case (state)
        RX_WAIT_LOW: begin
          ack_o <= 1'b0;
          if (!req_s) begin
            state  <= RX_IDLE;
            idle_o <= 1'b1;
          end
        end
        RX_IDLE: begin
          if (capture) begin
            ack_o  <= 1'b1;
            idle_o <= 1'b0;
            state  <= RX_ASSERT;
          end
        end
        RX_ASSERT: begin
          if (!req_s) begin
            ack_o  <= 1'b0;
            idle_o <= 1'b1;
            state  <= RX_IDLE;
          end
        end
        default: begin
          ack_o  <= 1'b0;
          idle_o <= 1'b0;
          state  <= RX_WAIT_LOW;
        end
      endcase
    end
  end

endmodule
